// File: rtl/lc_transition_ctrl.sv
// ---------------------------------------------------------------------------
// lc_transition_ctrl
//
// Lifecycle transition controller. A request from the security manager
// carries an owner identifier and a mode (advance by one state, or jump
// straight to the terminal/scrap state). The identifier is checked against a
// golden signature read from an external signature memory. A match applies
// the transition. A mismatch bumps a consecutive-failure counter, and enough
// mismatches in a row lock the block until reset. A memory read that never
// returns is abandoned after TIMEOUT cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   lc_req            transition request (level, held until lc_done)
//   lc_mode           0 = advance, 1 = scrap; sampled with lc_req
//   lc_identifier     candidate owner identifier; sampled with lc_req
//   sig_rd_en         signature memory read enable
//   sig_addr          signature slot (lc_state, or NUM_STATES for scrap)
//   sig_rd_data       golden signature returned by the memory
//   sig_valid         sig_rd_data qualifier
//   lc_state          current lifecycle state
//   lc_done           attempt complete (held until lc_req drops)
//   lc_success        attempt authenticated and applied
//   lc_error          0 none, 1 bad identifier, 2 already terminal, 3 timeout
//   lc_locked         permanent lockout active
//   fail_cnt          consecutive bad-identifier count
// ---------------------------------------------------------------------------
module lc_transition_ctrl #(
  parameter int ID_WIDTH   = 512,
  parameter int NUM_STATES = 6,
  parameter int STATE_W    = 3,
  parameter int INIT_STATE = 1,
  parameter int MAX_FAILS  = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             lc_req,
  input  logic                             lc_mode,
  input  logic [ID_WIDTH-1:0]              lc_identifier,
  output logic                             sig_rd_en,
  output logic [STATE_W-1:0]               sig_addr,
  input  logic [ID_WIDTH-1:0]              sig_rd_data,
  input  logic                             sig_valid,
  output logic [STATE_W-1:0]               lc_state,
  output logic                             lc_done,
  output logic                             lc_success,
  output logic [1:0]                       lc_error,
  output logic                             lc_locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [STATE_W-1:0] TERM_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] SCRAP_SLOT = STATE_W'(NUM_STATES);
  localparam logic [STATE_W-1:0] INIT_VAL   = STATE_W'(INIT_STATE);
  localparam logic [FC_W-1:0]    FAIL_MAX   = FC_W'(MAX_FAILS);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ID   = 2'd1;
  localparam logic [1:0] ERR_TERM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DONE   = 2'd2,
    LOCKED = 2'd3
  } fsm_t;

  fsm_t                state, state_n;
  logic [ID_WIDTH-1:0] id_reg, id_reg_n;
  logic                mode_reg, mode_reg_n;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_n;
  logic                sig_rd_en_n;
  logic [STATE_W-1:0]  sig_addr_n;
  logic [STATE_W-1:0]  lc_state_n;
  logic                lc_done_n, lc_success_n, lc_locked_n;
  logic [1:0]          lc_error_n;
  logic [FC_W-1:0]     fail_cnt_n;

  // Failure counter saturates so it can never wrap back to zero.
  function automatic logic [FC_W-1:0] sat_inc(input logic [FC_W-1:0] v);
    return (v >= FAIL_MAX) ? FAIL_MAX : FC_W'(v + 1'b1);
  endfunction

  // Target state of a successful transition; never steps past terminal.
  function automatic logic [STATE_W-1:0] next_lc(input logic [STATE_W-1:0] cur,
                                                 input logic scrap);
    if (scrap)                return TERM_STATE;
    else if (cur < TERM_STATE) return STATE_W'(cur + 1'b1);
    else                      return cur;
  endfunction

  always_comb begin
    state_n      = state;
    id_reg_n     = id_reg;
    mode_reg_n   = mode_reg;
    tmo_cnt_n    = tmo_cnt;
    sig_rd_en_n  = sig_rd_en;
    sig_addr_n   = sig_addr;
    lc_state_n   = lc_state;
    lc_done_n    = lc_done;
    lc_success_n = lc_success;
    lc_error_n   = lc_error;
    lc_locked_n  = lc_locked;
    fail_cnt_n   = fail_cnt;

    case (state)
      IDLE: begin
        if (lc_req) begin
          id_reg_n   = lc_identifier;
          mode_reg_n = lc_mode;
          if (lc_state == TERM_STATE) begin
            state_n      = DONE;
            lc_done_n    = 1'b1;
            lc_success_n = 1'b0;
            lc_error_n   = ERR_TERM;
          end else begin
            state_n     = FETCH;
            tmo_cnt_n   = '0;
            sig_rd_en_n = 1'b1;
            sig_addr_n  = lc_mode ? SCRAP_SLOT : lc_state;
          end
        end
      end

      FETCH: begin
        if (sig_valid) begin
          state_n     = DONE;
          sig_rd_en_n = 1'b0;
          tmo_cnt_n   = '0;
          lc_done_n   = 1'b1;
          if (sig_rd_data == id_reg) begin
            lc_state_n   = next_lc(lc_state, mode_reg);
            lc_success_n = 1'b1;
            lc_error_n   = ERR_NONE;
            fail_cnt_n   = '0;
          end else begin
            lc_success_n = 1'b0;
            lc_error_n   = ERR_ID;
            fail_cnt_n   = sat_inc(fail_cnt);
            id_reg_n     = '0;
            // Lock together with the failing lc_done, not one cycle later.
            if (sat_inc(fail_cnt) == FAIL_MAX) lc_locked_n = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_n      = DONE;
          sig_rd_en_n  = 1'b0;
          tmo_cnt_n    = '0;
          lc_done_n    = 1'b1;
          lc_success_n = 1'b0;
          lc_error_n   = ERR_TMO;
        end else begin
          tmo_cnt_n = TMO_W'(tmo_cnt + 1'b1);
        end
      end

      DONE: begin
        if (!lc_req) begin
          lc_done_n    = 1'b0;
          lc_success_n = 1'b0;
          lc_error_n   = ERR_NONE;
          id_reg_n     = '0;
          state_n      = lc_locked ? LOCKED : IDLE;
        end
      end

      // Terminal sink: only reset leaves.
      LOCKED: begin
        lc_locked_n = 1'b1;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      id_reg     <= '0;
      mode_reg   <= 1'b0;
      tmo_cnt    <= '0;
      sig_rd_en  <= 1'b0;
      sig_addr   <= '0;
      lc_state   <= INIT_VAL;
      lc_done    <= 1'b0;
      lc_success <= 1'b0;
      lc_error   <= ERR_NONE;
      lc_locked  <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      state      <= state_n;
      id_reg     <= id_reg_n;
      mode_reg   <= mode_reg_n;
      tmo_cnt    <= tmo_cnt_n;
      sig_rd_en  <= sig_rd_en_n;
      sig_addr   <= sig_addr_n;
      lc_state   <= lc_state_n;
      lc_done    <= lc_done_n;
      lc_success <= lc_success_n;
      lc_error   <= lc_error_n;
      lc_locked  <= lc_locked_n;
      fail_cnt   <= fail_cnt_n;
    end
  end

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc_transition_ctrl
//
// Directed bench for lc_transition_ctrl with default parameters. A signature
// memory model answers reads after a programmable latency (0 = never). The
// stimulus process queues the expected sig_addr of each read and the expected
// result of each completed attempt; a monitor pops and compares them when the
// DUT raises sig_rd_en / lc_done.
// ---------------------------------------------------------------------------
module tb_lc_transition_ctrl;

  localparam int ID_W = 512;

  logic            clk;
  logic            rst_n;
  logic            lc_req;
  logic            lc_mode;
  logic [ID_W-1:0] lc_identifier;
  logic            sig_rd_en;
  logic [2:0]      sig_addr;
  logic [ID_W-1:0] sig_rd_data;
  logic            sig_valid;
  logic [2:0]      lc_state;
  logic            lc_done;
  logic            lc_success;
  logic [1:0]      lc_error;
  logic            lc_locked;
  logic [1:0]      fail_cnt;

  lc_transition_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lc_req        (lc_req),
    .lc_mode       (lc_mode),
    .lc_identifier (lc_identifier),
    .sig_rd_en     (sig_rd_en),
    .sig_addr      (sig_addr),
    .sig_rd_data   (sig_rd_data),
    .sig_valid     (sig_valid),
    .lc_state      (lc_state),
    .lc_done       (lc_done),
    .lc_success    (lc_success),
    .lc_error      (lc_error),
    .lc_locked     (lc_locked),
    .fail_cnt      (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       success;
    logic [1:0] err;
    logic [2:0] st;
    logic [1:0] fc;
    logic       lk;
    logic       use_lat;
    logic [7:0] lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] addr_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         mem_lat = 2;
  logic [ID_W-1:0] sig_mem [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, none expected (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(input logic s, input logic [1:0] e, input logic [2:0] st,
                              input logic [1:0] fc, input logic lk, input int lat);
    exp_t r;
    r.success = s;  r.err = e;  r.st = st;  r.fc = fc;  r.lk = lk;
    r.use_lat = (lat >= 0);
    r.lat     = (lat >= 0) ? 8'(lat) : 8'd0;
    return r;
  endfunction

  // Signature memory model.
  initial begin
    int cnt;
    cnt = 0;
    sig_valid   = 1'b0;
    sig_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!sig_rd_en) begin
        cnt = 0;
        sig_valid = 1'b0;
      end else begin
        cnt++;
        if (mem_lat != 0 && cnt == mem_lat) begin
          sig_valid   = 1'b1;
          sig_rd_data = sig_mem[sig_addr];
        end else begin
          sig_valid = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_done, prev_rd;
    logic [2:0] prev_addr, a;
    int         cyc;
    exp_t       e;
    prev_done = 1'b0; prev_rd = 1'b0; prev_addr = '0; cyc = 0;
    forever begin
      @(negedge clk);
      if (sig_rd_en && !prev_rd) begin
        cyc = 0;
        if (addr_q.size() == 0) fail_now("unexpected_sig_rd_en");
        else begin
          a = addr_q.pop_front();
          chk("sig_addr", 64'(sig_addr), 64'(a));
        end
      end else begin
        cyc++;
      end
      if (sig_rd_en && prev_rd) chk("sig_addr_stable", 64'(sig_addr), 64'(prev_addr));
      if (lc_done && !prev_done) begin
        if (exp_q.size() == 0) fail_now("unexpected_lc_done");
        else begin
          e = exp_q.pop_front();
          chk("lc_success", 64'(lc_success), 64'(e.success));
          chk("lc_error",   64'(lc_error),   64'(e.err));
          chk("lc_state",   64'(lc_state),   64'(e.st));
          chk("fail_cnt",   64'(fail_cnt),   64'(e.fc));
          chk("lc_locked",  64'(lc_locked),  64'(e.lk));
          if (e.use_lat) chk("latency", 64'(cyc), 64'(e.lat));
        end
      end
      prev_done = lc_done;
      prev_rd   = sig_rd_en;
      prev_addr = sig_addr;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lc_state"},   64'(lc_state),   64'd1);
    chk({tag, "_lc_done"},    64'(lc_done),    64'd0);
    chk({tag, "_lc_success"}, 64'(lc_success), 64'd0);
    chk({tag, "_lc_error"},   64'(lc_error),   64'd0);
    chk({tag, "_lc_locked"},  64'(lc_locked),  64'd0);
    chk({tag, "_fail_cnt"},   64'(fail_cnt),   64'd0);
    chk({tag, "_sig_rd_en"},  64'(sig_rd_en),  64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    lc_req = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One request; addr < 0 means no memory read is expected.
  task automatic do_req(input logic mode, input logic [ID_W-1:0] id, input int addr,
                        input logic exp_done, input exp_t e);
    int waited;
    if (addr >= 0) addr_q.push_back(3'(addr));
    if (exp_done) exp_q.push_back(e);
    @(negedge clk);
    lc_req        = 1'b1;
    lc_mode       = mode;
    lc_identifier = id;
    if (!exp_done) begin
      repeat (10) @(negedge clk);
      lc_req = 1'b0;
      @(negedge clk);
      return;
    end
    waited = 0;
    while (!lc_done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!lc_done) begin
      chk("done_timeout", 64'(lc_done), 64'd1);
      lc_req = 1'b0;
      repeat (3) @(negedge clk);
      return;
    end
    repeat (3) @(negedge clk);
    chk("done_held", 64'(lc_done), 64'd1);
    chk("error_held", 64'(lc_error), 64'(e.err));
    lc_req = 1'b0;
    @(negedge clk);
    chk("done_clear", 64'(lc_done), 64'd0);
    chk("error_clear", 64'(lc_error), 64'd0);
    chk("success_clear", 64'(lc_success), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ID_W-1:0] bad;
    for (int i = 0; i < 8; i++) sig_mem[i] = {16{32'hC0DE_0000 | 32'(i)}};
    rst_n = 1'b0; lc_req = 1'b0; lc_mode = 1'b0; lc_identifier = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("init");
    rst_n = 1'b1;
    @(negedge clk);

    // Advance 1->2 with a two-cycle memory.
    mem_lat = 2;
    do_req(1'b0, sig_mem[1], 1, 1'b1, mk(1'b1, 2'd0, 3'd2, 2'd0, 1'b0, 2));
    // Advance to terminal with varying latency, then a refused request.
    mem_lat = 1;
    do_req(1'b0, sig_mem[2], 2, 1'b1, mk(1'b1, 2'd0, 3'd3, 2'd0, 1'b0, 1));
    mem_lat = 5;
    do_req(1'b0, sig_mem[3], 3, 1'b1, mk(1'b1, 2'd0, 3'd4, 2'd0, 1'b0, 5));
    mem_lat = 2;
    do_req(1'b0, sig_mem[4], 4, 1'b1, mk(1'b1, 2'd0, 3'd5, 2'd0, 1'b0, 2));
    do_req(1'b0, sig_mem[5], -1, 1'b1, mk(1'b0, 2'd2, 3'd5, 2'd0, 1'b0, -1));

    // Scrap from state 2.
    do_reset();
    do_req(1'b0, sig_mem[1], 1, 1'b1, mk(1'b1, 2'd0, 3'd2, 2'd0, 1'b0, 2));
    do_req(1'b1, sig_mem[6], 6, 1'b1, mk(1'b1, 2'd0, 3'd5, 2'd0, 1'b0, 2));

    // Wrong then right; then a timeout leaves fail_cnt alone.
    do_reset();
    bad = sig_mem[1]; bad[300] = ~bad[300];
    do_req(1'b0, bad, 1, 1'b1, mk(1'b0, 2'd1, 3'd1, 2'd1, 1'b0, 2));
    do_req(1'b0, sig_mem[1], 1, 1'b1, mk(1'b1, 2'd0, 3'd2, 2'd0, 1'b0, 2));
    bad = sig_mem[2]; bad[0] = ~bad[0];
    do_req(1'b0, bad, 2, 1'b1, mk(1'b0, 2'd1, 3'd2, 2'd1, 1'b0, 2));
    mem_lat = 0;
    do_req(1'b0, sig_mem[2], 2, 1'b1, mk(1'b0, 2'd3, 3'd2, 2'd1, 1'b0, 16));

    // Reset in the middle of a fetch.
    addr_q.push_back(3'd2);
    @(negedge clk);
    lc_req = 1'b1; lc_mode = 1'b0; lc_identifier = sig_mem[2];
    repeat (5) @(negedge clk);
    chk("mid_fetch_rd_en", 64'(sig_rd_en), 64'd1);
    rst_n  = 1'b0;
    lc_req = 1'b0;
    #1;
    check_reset_vals("mid_fetch_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_lat = 2;

    // Three wrong identifiers lock the block.
    bad = sig_mem[1]; bad[511] = ~bad[511];
    do_req(1'b0, bad, 1, 1'b1, mk(1'b0, 2'd1, 3'd1, 2'd1, 1'b0, 2));
    do_req(1'b1, bad, 6, 1'b1, mk(1'b0, 2'd1, 3'd1, 2'd2, 1'b0, 2));
    do_req(1'b0, bad, 1, 1'b1, mk(1'b0, 2'd1, 3'd1, 2'd3, 1'b1, 2));
    do_req(1'b0, sig_mem[1], -1, 1'b0, mk(1'b0, 2'd0, 3'd1, 2'd3, 1'b1, -1));
    chk("locked_hold", 64'(lc_locked), 64'd1);
    chk("locked_state", 64'(lc_state), 64'd1);
    chk("locked_fail_cnt", 64'(fail_cnt), 64'd3);
    chk("locked_rd_en", 64'(sig_rd_en), 64'd0);
    do_reset();
    check_reset_vals("post_lock");

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc_transition_ctrl.md
Name: lc_transition_ctrl

Overview:
Parametrised lifecycle (LC) transition controller, successor to the fixed 6-state, 512-bit LC protection block. It authenticates an owner identifier against a per-state golden signature held in an external signature memory and supports two modes: single-step advance and direct jump to the terminal (scrap) state. It adds a memory-read timeout, a consecutive-failure counter and a permanent lockout. It sits between the security-manager request interface and the LC signature memory, and drives lc_state to asset-gating logic.

Parameters:
ID_WIDTH, 512, identifier and signature width in bits
NUM_STATES, 6, number of LC states (0..NUM_STATES-1); the terminal state is NUM_STATES-1
STATE_W, 3, width of lc_state; must satisfy 2**STATE_W >= NUM_STATES+1
INIT_STATE, 1, lc_state value after reset
MAX_FAILS, 3, consecutive authentication failures that trigger lockout (>=1)
TIMEOUT, 16, maximum cycles spent in FETCH waiting for sig_valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lc_req  in  1  transition request, level; held until lc_done
lc_mode  in  1  0 = advance (+1), 1 = scrap (jump to terminal); sampled with lc_req
lc_identifier  in  ID_WIDTH  candidate owner identifier; sampled with lc_req
sig_rd_en  out  1  signature memory read enable
sig_addr  out  STATE_W  signature slot: lc_state for advance, NUM_STATES for scrap
sig_rd_data  in  ID_WIDTH  golden signature
sig_valid  in  1  sig_rd_data valid
lc_state  out  STATE_W  current LC state
lc_done  out  1  transition attempt complete
lc_success  out  1  attempt authenticated and applied
lc_error  out  2  0 none, 1 bad identifier, 2 already terminal, 3 timeout
lc_locked  out  1  lockout active
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive bad-identifier count

Behaviour:
- Reset (async): FSM=IDLE, lc_state=INIT_STATE, all other outputs 0, identifier register 0, timeout counter 0.
- FSM states: IDLE, FETCH, DONE, LOCKED.
- IDLE: when lc_req=1, latch lc_identifier and lc_mode.
  - If lc_state == NUM_STATES-1: go to DONE with lc_error=2, lc_success=0. No memory read and no fail_cnt change.
  - Otherwise go to FETCH. sig_rd_en=1 and sig_addr are registered, so both are valid from the first FETCH cycle.
- FETCH: hold sig_rd_en=1 and a stable sig_addr until sig_valid.
  - On sig_valid with a match: lc_state <= (mode ? NUM_STATES-1 : lc_state+1); lc_success=1; lc_error=0; fail_cnt=0; lc_done=1; go to DONE. All updates are visible the cycle after sig_valid.
  - On sig_valid with a mismatch: lc_error=1; fail_cnt+1 (saturating at MAX_FAILS); identifier register cleared; lc_done=1. If the new fail_cnt == MAX_FAILS, lc_locked=1 in the same cycle. Go to DONE.
  - TIMEOUT cycles in FETCH without sig_valid: lc_error=3, lc_done=1, go to DONE. fail_cnt is unchanged.
  - sig_rd_en drops the cycle after leaving FETCH.
- lc_req deasserting during FETCH does not abort the attempt; the attempt completes normally.
- DONE: outputs hold until lc_req=0. In that cycle lc_done, lc_success and lc_error clear and the identifier register clears. Next state is LOCKED if lc_locked=1, else IDLE.
- LOCKED: lc_req is ignored, lc_done stays 0, lc_state is frozen, lc_locked=1. Only reset exits this state.
- Arithmetic: lc_state only increments when below the terminal value, so it never wraps. Scrap from state NUM_STATES-2 is equivalent to advance.
- sig_valid outside FETCH is ignored.
- Reset mid-attempt returns every output to reset values, including lc_state=INIT_STATE and fail_cnt=0.

Test Plan:
1. Reset; lc_req=1, mode=0, ID equals slot-1 signature, sig_valid 2 cycles after sig_rd_en -> sig_addr=1, lc_state 1->2, lc_success=1, lc_error=0, lc_done held until lc_req=0.
2. Advance repeatedly to state 5, then request again -> no sig_rd_en, lc_done=1, lc_error=2, lc_state stays 5.
3. From state 2, mode=1, ID equals slot-6 (scrap) signature -> sig_addr=6, lc_state=5, lc_success=1.
4. Three wrong IDs with MAX_FAILS=3 -> fail_cnt 1, 2, 3, lc_error=1 each time, lc_locked=1 with the third lc_done. A subsequent correct request produces no sig_rd_en and no lc_done. Assert rst_n -> lc_locked=0, lc_state=1.
5. Wrong ID, then correct ID -> fail_cnt 1 then 0; lc_state advances once.
6. sig_valid never asserted -> after 16 FETCH cycles lc_error=3, lc_done=1, fail_cnt unchanged. Reset asserted mid-FETCH -> all outputs at reset values immediately.
